// File: rtl/pushbutton_pio_pkg.sv
// pushbutton_pio_pkg: register addresses and edge-type encodings shared by the pushbutton port
package pushbutton_pio_pkg;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: one-channel level filter; a new level is accepted once it has persisted DEBOUNCE_CYCLES cycles
module pb_debounce #(
    parameter int IDLE_LEVEL      = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic s2_i,
    output logic stb_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic stb_q, stb_d;
    // count consecutive disagreement; any agreement or acceptance restarts from zero, so it never wraps
    always_comb begin
        cnt_d = (s2_i == stb_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        stb_d = (s2_i != stb_q && cnt_q == LAST) ? s2_i : stb_q;
    end
    // counter and accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            stb_q <= (IDLE_LEVEL != 0);
        end else begin
            cnt_q <= cnt_d;
            stb_q <= stb_d;
        end
    end
    assign stb_o = stb_q;
endmodule

// File: rtl/pushbutton_edge_pio.sv
// pushbutton_edge_pio: Avalon-MM edge-capturing input port; PUSHBUTTON_DEBOUNCE_EN adds per-channel debounce
module pushbutton_edge_pio
    import pushbutton_pio_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam logic [WIDTH-1:0] IDLE_V = (IDLE_LEVEL != 0) ? '1 : '0;
    logic [WIDTH-1:0] s1_q, s2_q, stb_q, prev_q, mask_q, mask_d, cap_q, cap_d, edge_v, clr;
    logic [31:0] rd_d;
    logic wr;
    logic unused_bits;
    assign unused_bits = ^{writedata, 32'(DEBOUNCE_CYCLES)};
`ifdef PUSHBUTTON_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        pb_debounce #(.IDLE_LEVEL(IDLE_LEVEL), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .reset(reset), .s2_i(s2_q[i]), .stb_o(stb_q[i])
        );
    end
`else
    // stable vector is the synchroniser output delayed one register
    always_ff @(posedge clk) begin
        stb_q <= reset ? IDLE_V : s2_q;
    end
`endif
    // next-state for edge detect, capture (set beats clear), mask and read mux
    always_comb begin
        wr     = chipselect && !write_n;
        edge_v = EDGE_TYPE == EDGE_RISE ? stb_q & ~prev_q :
                 EDGE_TYPE == EDGE_FALL ? ~stb_q & prev_q : stb_q ^ prev_q;
        clr    = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        cap_d  = (cap_q & ~clr) | edge_v;
        mask_d = (wr && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
        rd_d   = address == ADDR_DATA ? 32'(stb_q) :
                 address == ADDR_MASK ? 32'(mask_q) :
                 address == ADDR_EDGE ? 32'(cap_q) : '0;
    end
    // synchroniser, edge history, registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= IDLE_V;
            s2_q     <= IDLE_V;
            prev_q   <= IDLE_V;
            cap_q    <= '0;
            mask_q   <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            s1_q     <= in_port;
            s2_q     <= s1_q;
            prev_q   <= stb_q;
            cap_q    <= cap_d;
            mask_q   <= mask_d;
            readdata <= rd_d;
            irq      <= |(cap_q & mask_q);
        end
    end
endmodule

// File: tb/tb_pushbutton_edge_pio.sv
// tb_pushbutton_edge_pio: self-checking bench for the pushbutton edge port
module tb_pushbutton_edge_pio;
    localparam int DC = 16;
`ifdef PUSHBUTTON_DEBOUNCE_EN
    localparam int LAT = 4 + DC;
    localparam logic [31:0] PULSE_EXP = 32'h0;
`else
    localparam int LAT = 5;
    localparam logic [31:0] PULSE_EXP = 32'h80;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] address = 2'd0;
    logic chipselect = 1'b0, write_n = 1'b1;
    logic [31:0] writedata = '0, readdata;
    logic [1:0] in_port = 2'b11;
    logic irq;
    logic [1:0] addr8 = 2'd3;
    logic cs8 = 1'b0, wn8 = 1'b1;
    logic [31:0] wd8 = '0, rd8;
    logic [7:0] in8 = 8'h00;
    logic irq8;
    int n_vec = 0, n_err = 0;

    typedef struct { string name; logic [31:0] exp; } exp_t;
    typedef struct { string name; logic wr; logic [1:0] addr; logic [31:0] wdata; logic [31:0] exp_rd; } vec_t;
    exp_t sb[$];
    vec_t vt[10];

    pushbutton_edge_pio #(.WIDTH(2), .EDGE_TYPE(1), .IDLE_LEVEL(1), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(readdata), .irq(irq)
    );
    pushbutton_edge_pio #(.WIDTH(8), .EDGE_TYPE(2), .IDLE_LEVEL(0), .DEBOUNCE_CYCLES(DC)) dut8 (
        .clk(clk), .reset(reset), .address(addr8), .chipselect(cs8), .write_n(wn8),
        .writedata(wd8), .in_port(in8), .readdata(rd8), .irq(irq8)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input string name, input logic wr, input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        address = a;
        chipselect = 1'b1;
        write_n = !wr;
        writedata = d;
        if (!wr) sb.push_back('{name, exp});
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
        if (!wr) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: scoreboard empty", name);
            end else begin
                e = sb.pop_front();
                check(e.name, readdata, e.exp);
            end
        end
    endtask

    initial begin
        vt[0] = '{"data_idle",   1'b0, 2'd0, 32'h0,        32'h3};
        vt[1] = '{"addr1_rd",    1'b0, 2'd1, 32'h0,        32'h0};
        vt[2] = '{"mask_reset",  1'b0, 2'd2, 32'h0,        32'h0};
        vt[3] = '{"cap_idle",    1'b0, 2'd3, 32'h0,        32'h0};
        vt[4] = '{"addr1_wr",    1'b1, 2'd1, 32'hFFFFFFFF, 32'h0};
        vt[5] = '{"addr1_after", 1'b0, 2'd1, 32'h0,        32'h0};
        vt[6] = '{"mask_wr_all", 1'b1, 2'd2, 32'hFFFFFFFF, 32'h0};
        vt[7] = '{"mask_all",    1'b0, 2'd2, 32'h0,        32'h3};
        vt[8] = '{"mask_wr_b0",  1'b1, 2'd2, 32'h1,        32'h0};
        vt[9] = '{"mask_b0",     1'b0, 2'd2, 32'h0,        32'h1};

        repeat (3) tick();
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rd8", rd8, 32'h0);
        reset = 1'b0;
        repeat (50) tick();
        check("hold_irq", {31'h0, irq}, 32'h0);

        for (int i = 0; i < 10; i++) bus(vt[i].name, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_rd);
        check("irq_no_cap", {31'h0, irq}, 32'h0);

        in_port = 2'b10;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            check($sformatf("irq_lat_%0d", i), {31'h0, irq}, {31'h0, i == LAT});
        end
        bus("cap_fall", 1'b0, 2'd3, 32'h0, 32'h1);
        bus("data_fall", 1'b0, 2'd0, 32'h0, 32'h2);
        bus("clr_wr", 1'b1, 2'd3, 32'h1, 32'h0);
        check("irq_hold", {31'h0, irq}, 32'h1);
        tick();
        check("irq_clear", {31'h0, irq}, 32'h0);
        bus("cap_cleared", 1'b0, 2'd3, 32'h0, 32'h0);

        in_port = 2'b11;
        repeat (LAT + 2) tick();
        bus("rise_ignored", 1'b0, 2'd3, 32'h0, 32'h0);

        in_port = 2'b10;
        repeat (LAT - 2) tick();
        bus("set_wins_wr", 1'b1, 2'd3, 32'h1, 32'h0);
        bus("set_wins", 1'b0, 2'd3, 32'h0, 32'h1);
        check("set_wins_irq", {31'h0, irq}, 32'h1);
        in_port = 2'b11;
        repeat (LAT + 2) tick();
        bus("clr2_wr", 1'b1, 2'd3, 32'h3, 32'h0);
        tick();
        check("irq_clear2", {31'h0, irq}, 32'h0);

        in8 = 8'h80;
        repeat (3) tick();
        in8 = 8'h00;
        repeat (4) tick();
        check("any_pulse", rd8, PULSE_EXP);
        repeat (20) tick();
        check("any_sticky", rd8, PULSE_EXP);
        check("any_irq8", {31'h0, irq8}, 32'h0);

`ifdef PUSHBUTTON_DEBOUNCE_EN
        bus("mask_wr_b1", 1'b1, 2'd2, 32'h2, 32'h0);
        for (int k = 0; k < 8; k++) begin
            in_port[1] = ~in_port[1];
            repeat (5) tick();
            check($sformatf("bounce_irq_%0d", k), {31'h0, irq}, 32'h0);
        end
        in_port[1] = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            check($sformatf("bounce_lat_%0d", i), {31'h0, irq}, {31'h0, i == LAT});
        end
        bus("bounce_cap", 1'b0, 2'd3, 32'h0, 32'h2);
        bus("bounce_data", 1'b0, 2'd0, 32'h0, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
